dmem_sys_arbiter: RTL and testbench

DMEM_SYS_ARBITER -- requirements
Module: dmem_sys_arbiter

---
 rtl/dmem_sys_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_sys_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sys_arbiter.sv
// rtl/dmem_sys_arbiter.sv - data-memory port arbiter with a print-string syscall engine
// Optional newline after each string: define DMEM_SYS_NEWLINE_EN.
module dmem_sys_arbiter #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_we8,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        sys,
  input  logic [31:0] regv,
  input  logic [31:0] rega,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic        mem_we8,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        char_valid,
  output logic [7:0]  char_data,
  input  logic        char_ready,
  output logic        sys_busy,
  output logic        sys_done
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, NL, DONE} state_t;

  state_t        state, state_nx;
  logic [31:0]   ptr, ptr_nx;
  logic [31:0]   word, word_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    idx, idx_nx;
  logic          sys_q;
  logic          sys_edge;
  logic [7:0]    cur_byte;
  logic          advance;

  // Only a fresh rising edge starts work; a held level is ignored.
  assign sys_edge = sys & ~sys_q;
  assign cur_byte = word[{idx, 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      word  <= '0;
      cnt   <= '0;
      idx   <= '0;
      sys_q <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      word  <= word_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      sys_q <= sys;
    end
  end

  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    word_nx    = word;
    cnt_nx     = cnt;
    idx_nx     = idx;
    advance    = 1'b0;
    mem_addr   = ptr;
    mem_we     = 1'b0;
    mem_we8    = 1'b0;
    mem_wdata  = '0;
    cpu_rdata  = mem_rdata;
    cpu_stall  = cpu_req;
    char_valid = 1'b0;
    char_data  = '0;
    sys_busy   = (state != IDLE);
    sys_done   = 1'b0;

    case (state)
      IDLE: begin
        mem_addr  = cpu_addr;
        mem_we    = cpu_we;
        mem_we8   = cpu_we8;
        mem_wdata = cpu_wdata;
        cpu_stall = 1'b0;
        if (sys_edge) begin
          if (regv == 32'd4) begin
            ptr_nx   = rega;
            cnt_nx   = '0;
            state_nx = FETCH;
          end else begin
            state_nx = DONE;
          end
        end
      end

      FETCH: begin
        if (mem_rdata == 32'd0) begin
          state_nx = NL;
        end else begin
          word_nx  = mem_rdata;
          idx_nx   = 2'd0;
          cnt_nx   = cnt + 1'b1;
          state_nx = EMIT;
        end
      end

      EMIT: begin
        char_data  = cur_byte;
        char_valid = (cur_byte != 8'd0);
        // Zero bytes are dropped without a handshake.
        advance    = (cur_byte == 8'd0) || char_ready;
        if (advance) begin
          if (idx == 2'd3) begin
            idx_nx   = 2'd0;
            ptr_nx   = ptr + 32'd1;
            state_nx = (cnt == CW'(MAX_WORDS)) ? NL : FETCH;
          end else begin
            idx_nx = idx + 2'd1;
          end
        end
      end

      NL: begin
`ifdef DMEM_SYS_NEWLINE_EN
        char_data  = 8'h0A;
        char_valid = 1'b1;
        if (char_ready) state_nx = DONE;
`else
        state_nx = DONE;
`endif
      end

      DONE: begin
        sys_done = 1'b1;
        state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_sys_arbiter.sv
// tb/tb_dmem_sys_arbiter.sv - directed bench for dmem_sys_arbiter
module tb_dmem_sys_arbiter;

`ifdef DMEM_SYS_NEWLINE_EN
  localparam bit NL_EN = 1'b1;
`else
  localparam bit NL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_we8;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        sys;
  logic [31:0] regv, rega;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_we8;
  logic        char_valid, char_ready;
  logic [7:0]  char_data;
  logic        sys_busy, sys_done;

  always #5 clk = ~clk;

  dmem_sys_arbiter #(.MAX_WORDS(2)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_we8(cpu_we8),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .sys(sys), .regv(regv), .rega(rega),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_we8(mem_we8),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .sys_busy(sys_busy), .sys_done(sys_done)
  );

  // Address 0xFFFFFFFF aliases to index 0x3FF.
  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[9:0]];

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] got[$];
  int done_cnt = 0;
  int we_cnt = 0;
  int stab_err = 0;
  logic pend = 1'b0;
  logic [7:0] pend_data = 8'd0;

  always @(negedge clk) begin
    if (char_valid && char_ready) got.push_back(char_data);
    if (sys_done) done_cnt <= done_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
    if (char_valid && pend && char_data !== pend_data) stab_err <= stab_err + 1;
    pend      <= char_valid && !char_ready;
    pend_data <= char_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, input bit toggle, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sys_done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      if (toggle) char_ready = ~char_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_req = 1'b1; cpu_addr = 32'h123;
    mem[10'h123] = 32'hCAFE0001;
    step();
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL reset_char_valid got %b exp 0", char_valid); end
    n_checks++; if (char_data !== 8'd0) begin n_fail++; $display("FAIL reset_char_data got %h exp 00", char_data); end
    n_checks++; if (sys_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sys_busy got %b exp 0", sys_busy); end
    n_checks++; if (sys_done !== 1'b0) begin n_fail++; $display("FAIL reset_sys_done got %b exp 0", sys_done); end
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_stall got %b exp 0", cpu_stall); end
    n_checks++; if (mem_addr !== 32'h123) begin n_fail++; $display("FAIL reset_addr_pass got %h exp 00000123", mem_addr); end
    n_checks++; if (cpu_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL reset_rdata_pass got %h exp cafe0001", cpu_rdata); end
    reset = 1'b0; cpu_req = 1'b0;
    step();
  endtask

  task automatic test_hello(input bit toggle);
    logic [7:0] exp[$];
    bit ok;
    int d0, s0;
    exp = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h21};
    if (NL_EN) exp.push_back(8'h0A);
    got.delete();
    d0 = done_cnt; s0 = stab_err;
    char_ready = !toggle;
    regv = 32'd4; rega = 32'h100; sys = 1'b1;
    step();
    sys = 1'b0;
    n_checks++; if (sys_busy !== 1'b1) begin n_fail++; $display("FAIL hello_busy got %b exp 1", sys_busy); end
    wait_done(300, toggle, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL hello_timeout got no sys_done exp sys_done"); end
    char_ready = 1'b1;
    step(); step();
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL hello_done_pulses got %0d exp 1", done_cnt - d0); end
    n_checks++; if (sys_busy !== 1'b0) begin n_fail++; $display("FAIL hello_idle_busy got %b exp 0", sys_busy); end
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL hello_len toggle=%0d got %0d exp %0d", toggle, got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL hello_char[%0d] got %h exp %h", i, (i < got.size()) ? got[i] : 8'hXX, exp[i]);
      end
    end
    if (toggle) begin
      n_checks++; if (stab_err - s0 !== 0) begin n_fail++; $display("FAIL hold_stable got %0d changes exp 0", stab_err - s0); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int w0;
    char_ready = 1'b1;
    regv = 32'd4; rega = 32'h100; sys = 1'b1;
    step();
    sys = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hDEADBEEF;
    #1;
    w0 = we_cnt;
    n_checks++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL stall_busy got %b exp 1", cpu_stall); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL stall_mem_we got %b exp 0", mem_we); end
    wait_done(300, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stall_timeout got no sys_done exp sys_done"); end
    n_checks++; if (we_cnt !== w0) begin n_fail++; $display("FAIL stall_writes got %0d exp 0", we_cnt - w0); end
    step();
    n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL after_stall got %b exp 0", cpu_stall); end
    n_checks++; if (mem_we !== 1'b1 || mem_we8 !== 1'b0) begin n_fail++; $display("FAIL after_we got %b%b exp 10", mem_we, mem_we8); end
    n_checks++; if (mem_addr !== 32'h200) begin n_fail++; $display("FAIL after_addr got %h exp 00000200", mem_addr); end
    n_checks++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL after_wdata got %h exp deadbeef", mem_wdata); end
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
  endtask

  task automatic test_other_syscall();
    int d0, c0;
    d0 = done_cnt; c0 = got.size();
    char_ready = 1'b1;
    regv = 32'd10; sys = 1'b1;
    step();
    n_checks++; if (sys_done !== 1'b1) begin n_fail++; $display("FAIL other_done_edge got %b exp 1", sys_done); end
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL other_no_char got %b exp 0", char_valid); end
    step();
    n_checks++; if (sys_done !== 1'b0) begin n_fail++; $display("FAIL other_done_width got %b exp 0", sys_done); end
    step(); step(); step();
    sys = 1'b0;
    step(); step();
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL other_held_level got %0d pulses exp 1", done_cnt - d0); end
    n_checks++; if (got.size() !== c0) begin n_fail++; $display("FAIL other_chars got %0d exp %0d", got.size(), c0); end
  endtask

  task automatic test_max_words();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    if (NL_EN) exp.push_back(8'h0A);
    got.delete();
    char_ready = 1'b1;
    regv = 32'd4; rega = 32'h300; sys = 1'b1;
    step();
    sys = 1'b0;
    wait_done(300, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL maxw_timeout got no sys_done exp sys_done"); end
    step(); step();
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL maxw_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL maxw_char[%0d] got %h exp %h", i, (i < got.size()) ? got[i] : 8'hXX, exp[i]);
      end
    end
    // Mid-EMIT reset with an unaccepted character pending.
    got.delete();
    char_ready = 1'b0;
    sys = 1'b1;
    step();
    sys = 1'b0;
    step();
    n_checks++; if (char_valid !== 1'b1 || char_data !== 8'h41) begin n_fail++; $display("FAIL midreset_pre got %b/%h exp 1/41", char_valid, char_data); end
    reset = 1'b1;
    #1;
    n_checks++; if (char_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b exp 0", char_valid); end
    n_checks++; if (sys_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b exp 0", sys_busy); end
    n_checks++; if (char_data !== 8'd0) begin n_fail++; $display("FAIL midreset_data got %h exp 00", char_data); end
    step();
    reset = 1'b0; char_ready = 1'b1;
    step(); step(); step();
    n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL midreset_chars got %0d exp 0", got.size()); end
    n_checks++; if (sys_busy !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got %b exp 0", sys_busy); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp[$];
    bit ok;
    exp = '{8'h41, 8'h41, 8'h41, 8'h41};
    if (NL_EN) exp.push_back(8'h0A);
    got.delete();
    char_ready = 1'b1;
    regv = 32'd4; rega = 32'hFFFFFFFF; sys = 1'b1;
    step();
    sys = 1'b0;
    n_checks++; if (mem_addr !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL wrap_start_addr got %h exp ffffffff", mem_addr); end
    wait_done(100, 1'b0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout got no sys_done exp sys_done"); end
    step(); step();
    n_checks++; if (got.size() !== exp.size()) begin n_fail++; $display("FAIL wrap_len got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      n_checks++;
      if (i >= got.size() || got[i] !== exp[i]) begin
        n_fail++; $display("FAIL wrap_char[%0d] got %h exp %h", i, (i < got.size()) ? got[i] : 8'hXX, exp[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_we8 = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; sys = 1'b0; regv = '0; rega = '0; char_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[10'h100] = 32'h6C6C6548;
    mem[10'h101] = 32'h0000216F;
    mem[10'h102] = 32'h00000000;
    mem[10'h300] = 32'h44434241;
    mem[10'h301] = 32'h48474645;
    mem[10'h302] = 32'h4C4B4A49;
    mem[10'h3FF] = 32'h41414141;

    test_reset();
    test_hello(1'b0);
    test_hello(1'b1);
    test_stall();
    test_other_syscall();
    test_max_words();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
